// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
package mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand-in / result-out handshake bundle for mac_accumulator.
import mac_pkg::*;

interface mac_accumulator_if #(
    parameter int ACC_W   = 12,
    parameter int COUNT_W = 8
) ();

    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_a;
    logic [OP_W-1:0]    in_b;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_ovf;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );

endinterface

// File: rtl/mac_accumulator_array_multi.sv
// 4x4 unsigned array multiplier: shifted AND rows summed, purely combinational.
module array_multi
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) begin
                p = p + (PROD_W'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming MAC: registered product stage, accumulate stage, and result hold FSM.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int COUNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mac_accumulator_if.slave  bus
);

    state_t              state;
    logic                in_ready;
    logic                accept;
    logic [PROD_W-1:0]   prod;

    logic                p_valid;
    logic                p_last;
    logic [PROD_W-1:0]   p_prod;

    logic [ACC_W-1:0]    acc;
    logic                ovf;
    logic [COUNT_W-1:0]  count;

    logic [ACC_W:0]      sum_ext;
    logic [ACC_W-1:0]    acc_next;
    logic                ovf_next;
    logic [COUNT_W-1:0]  count_next;

    logic                out_valid;
    logic [ACC_W-1:0]    out_sum;
    logic                out_ovf;
    logic [COUNT_W-1:0]  out_count;

    assign in_ready = (state == ACC);
    assign accept   = bus.in_valid && in_ready;

    array_multi u_mult (
        .a (bus.in_a),
        .b (bus.in_b),
        .p (prod)
    );

    // Extra top bit of sum_ext catches the carry leaving the accumulator.
    assign sum_ext    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_prod};
    assign acc_next   = sum_ext[ACC_W-1:0];
    assign ovf_next   = ovf | sum_ext[ACC_W];
    assign count_next = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            count   <= '0;
        end else begin
            p_valid <= accept;
            p_last  <= accept && bus.in_last;
            if (accept) begin
                p_prod <= prod;
            end
            if (p_valid) begin
                if (p_last) begin
                    acc   <= '0;
                    ovf   <= 1'b0;
                    count <= '0;
                end else begin
                    acc   <= acc_next;
                    ovf   <= ovf_next;
                    count <= count_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (accept && bus.in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (p_valid && p_last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        out_ovf   <= ovf_next;
                        out_count <= count_next;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_ovf   = out_ovf;
    assign bus.out_count = out_count;

endmodule
